// File: rtl/alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_decoder
// Brief    : RV32I ALU control unit. Combinational aluop/funct3/funct7 decode
//            into the 4-bit ALU select, with a registered copy of the result.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] aluop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic [3:0] alu_control_q,
    output logic       illegal,
    output logic       illegal_q
);

    // Instruction classes from the main control unit
    localparam logic [2:0] c_R_TYPE = 3'b000;
    localparam logic [2:0] c_I_TYPE = 3'b001;
    localparam logic [2:0] c_LOAD   = 3'b010;
    localparam logic [2:0] c_STORE  = 3'b011;
    localparam logic [2:0] c_BRANCH = 3'b100;
    localparam logic [2:0] c_U_TYPE = 3'b101;
    localparam logic [2:0] c_JUMP   = 3'b110;
    localparam logic [2:0] c_NOP    = 3'b111;

    // ALU operation selects
    localparam logic [3:0] c_ADD   = 4'b0000;
    localparam logic [3:0] c_SUB   = 4'b0001;
    localparam logic [3:0] c_SLL   = 4'b0010;
    localparam logic [3:0] c_LT    = 4'b0011;
    localparam logic [3:0] c_LTU   = 4'b0100;
    localparam logic [3:0] c_XOR   = 4'b0101;
    localparam logic [3:0] c_SRL   = 4'b0110;
    localparam logic [3:0] c_SRA   = 4'b0111;
    localparam logic [3:0] c_OR    = 4'b1000;
    localparam logic [3:0] c_AND   = 4'b1001;
    localparam logic [3:0] c_EQ    = 4'b1010;
    localparam logic [3:0] c_NE    = 4'b1011;
    localparam logic [3:0] c_GE    = 4'b1100;
    localparam logic [3:0] c_GEU   = 4'b1101;
    localparam logic [3:0] c_PC4   = 4'b1110;

    logic [3:0] alu_control_d;
    logic       illegal_d;

    // Only funct7[5] distinguishes SUB/SRA; the remaining bits are don't-care.
    logic w_unused_funct7;
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_control_d = c_ADD;
        illegal_d     = 1'b0;
        case (aluop)
            c_R_TYPE, c_I_TYPE: begin
                case (funct3)
                    // ADDI has no SUB form, so funct7 only matters for R-type here
                    3'b000:  alu_control_d = (aluop == c_R_TYPE && funct7[5]) ? c_SUB : c_ADD;
                    3'b001:  alu_control_d = c_SLL;
                    3'b010:  alu_control_d = c_LT;
                    3'b011:  alu_control_d = c_LTU;
                    3'b100:  alu_control_d = c_XOR;
                    3'b101:  alu_control_d = funct7[5] ? c_SRA : c_SRL;
                    3'b110:  alu_control_d = c_OR;
                    3'b111:  alu_control_d = c_AND;
                    default: alu_control_d = c_ADD;
                endcase
            end
            c_BRANCH: begin
                case (funct3)
                    3'b000:  alu_control_d = c_EQ;
                    3'b001:  alu_control_d = c_NE;
                    3'b100:  alu_control_d = c_LT;
                    3'b101:  alu_control_d = c_GE;
                    3'b110:  alu_control_d = c_LTU;
                    3'b111:  alu_control_d = c_GEU;
                    3'b010, 3'b011: begin
                        alu_control_d = c_ADD;
                        illegal_d     = 1'b1;
                    end
                    default: alu_control_d = c_ADD;
                endcase
            end
            c_JUMP:                             alu_control_d = c_PC4;
            c_LOAD, c_STORE, c_U_TYPE, c_NOP:   alu_control_d = c_ADD;
            default:                            alu_control_d = c_ADD;
        endcase
    end

    assign alu_control = alu_control_d;
    assign illegal     = illegal_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_control_q <= c_ADD;
            illegal_q     <= 1'b0;
        end else begin
            alu_control_q <= alu_control_d;
            illegal_q     <= illegal_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_decoder
// Brief    : Directed self-checking bench for alu_ctrl_decoder.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] aluop;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_control;
    logic [3:0] alu_control_q;
    logic       illegal;
    logic       illegal_q;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .aluop         (aluop),
        .funct3        (funct3),
        .funct7        (funct7),
        .alu_control   (alu_control),
        .alu_control_q (alu_control_q),
        .illegal       (illegal),
        .illegal_q     (illegal_q)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        aluop = 3'b110; funct3 = 3'b000; funct7 = 7'b0000000;
        rst   = 1'b1;
        #1;
        n_cmp++;
        if (alu_control_q !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl_q: got %b want 0000", alu_control_q);
        end
        n_cmp++;
        if (illegal_q !== 1'b0) begin
            n_err++;
            $display("FAIL reset_illegal_q: got %b want 0", illegal_q);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (alu_control_q !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold_q: got %b want 0000", alu_control_q);
        end
        n_cmp++;
        if (alu_control !== 4'b1110) begin
            n_err++;
            $display("FAIL reset_comb_unaffected: got %b want 1110", alu_control);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_r_type();
        logic [3:0] e_plain [8];
        logic [3:0] e_alt   [8];
        e_plain = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
        e_alt   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9};
        for (int f = 0; f < 8; f++) begin
            aluop = 3'b000; funct3 = 3'(f);
            funct7 = 7'b0000000; #1;
            n_cmp++;
            if (alu_control !== e_plain[f] || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL r_type f3=%0d f7=00: got %b/%b want %b/0", f, alu_control, illegal, e_plain[f]);
            end
            funct7 = 7'b0100000; #1;
            n_cmp++;
            if (alu_control !== e_alt[f] || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL r_type f3=%0d f7=20: got %b/%b want %b/0", f, alu_control, illegal, e_alt[f]);
            end
            funct7 = 7'b1011111; #1;
            n_cmp++;
            if (alu_control !== e_plain[f]) begin
                n_err++;
                $display("FAIL r_type_f7_ignored f3=%0d: got %b want %b", f, alu_control, e_plain[f]);
            end
        end
    endtask

    task automatic test_i_type();
        logic [3:0] e_plain [8];
        logic [3:0] e_alt   [8];
        e_plain = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
        e_alt   = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9};
        for (int f = 0; f < 8; f++) begin
            aluop = 3'b001; funct3 = 3'(f);
            funct7 = 7'b0000000; #1;
            n_cmp++;
            if (alu_control !== e_plain[f] || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL i_type f3=%0d f7=00: got %b/%b want %b/0", f, alu_control, illegal, e_plain[f]);
            end
            funct7 = 7'b0100000; #1;
            n_cmp++;
            if (alu_control !== e_alt[f] || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL i_type f3=%0d f7=20: got %b/%b want %b/0", f, alu_control, illegal, e_alt[f]);
            end
        end
    endtask

    task automatic test_add_classes();
        logic [2:0] cls [4];
        cls = '{3'b010, 3'b011, 3'b101, 3'b111};
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 6; k++) begin
                aluop  = cls[c];
                funct3 = 3'($urandom_range(0, 7));
                funct7 = 7'($urandom_range(0, 127));
                #1;
                n_cmp++;
                if (alu_control !== 4'b0000 || illegal !== 1'b0) begin
                    n_err++;
                    $display("FAIL add_class op=%b f3=%b f7=%b: got %b/%b want 0000/0",
                             aluop, funct3, funct7, alu_control, illegal);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] e_op  [8];
        logic       e_ill [8];
        e_op  = '{4'hA, 4'hB, 4'h0, 4'h0, 4'h3, 4'hC, 4'h4, 4'hD};
        e_ill = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int f = 0; f < 8; f++) begin
            aluop = 3'b100; funct3 = 3'(f);
            funct7 = (f % 2 == 0) ? 7'b0100000 : 7'b1111111;
            #1;
            n_cmp++;
            if (alu_control !== e_op[f] || illegal !== e_ill[f]) begin
                n_err++;
                $display("FAIL branch f3=%0d: got %b/%b want %b/%b", f, alu_control, illegal, e_op[f], e_ill[f]);
            end
        end
    endtask

    task automatic test_jump();
        for (int k = 0; k < 8; k++) begin
            aluop  = 3'b110;
            funct3 = 3'(k);
            funct7 = 7'($urandom_range(0, 127));
            #1;
            n_cmp++;
            if (alu_control !== 4'b1110 || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL jump f3=%0d: got %b/%b want 1110/0", k, alu_control, illegal);
            end
        end
    endtask

    task automatic test_registered();
        // Load a non-reset value into the register first.
        @(negedge clk);
        aluop = 3'b100; funct3 = 3'b010; funct7 = 7'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (alu_control_q !== 4'b0000 || illegal_q !== 1'b1) begin
            n_err++;
            $display("FAIL reg_illegal_capture: got %b/%b want 0000/1", alu_control_q, illegal_q);
        end
        @(negedge clk);
        aluop = 3'b110; funct3 = 3'b000;
        @(posedge clk); #1;
        n_cmp++;
        if (alu_control_q !== 4'b1110 || illegal_q !== 1'b0) begin
            n_err++;
            $display("FAIL reg_jump_capture: got %b/%b want 1110/0", alu_control_q, illegal_q);
        end
        // Asynchronous reset between edges
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (alu_control_q !== 4'b0000 || illegal_q !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b/%b want 0000/0", alu_control_q, illegal_q);
        end
        n_cmp++;
        if (alu_control !== 4'b1110) begin
            n_err++;
            $display("FAIL reset_midop_comb: got %b want 1110", alu_control);
        end
        @(negedge clk);
        rst = 1'b0; aluop = 3'b110;
        #1;
        n_cmp++;
        if (alu_control_q !== 4'b0000) begin
            n_err++;
            $display("FAIL reg_before_edge: got %b want 0000", alu_control_q);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (alu_control_q !== 4'b1110) begin
            n_err++;
            $display("FAIL reg_after_edge: got %b want 1110", alu_control_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] v_op  [6];
        logic [2:0] v_f3  [6];
        logic [6:0] v_f7  [6];
        logic [3:0] v_exp [6];
        logic       v_ill [6];
        v_op  = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b100, 3'b010};
        v_f3  = '{3'b000, 3'b011, 3'b011, 3'b101, 3'b111, 3'b001};
        v_f7  = '{7'h20,  7'h00,  7'h00,  7'h20,  7'h00,  7'h7F};
        v_exp = '{4'h1,   4'h0,   4'hE,   4'h7,   4'hD,   4'h0};
        v_ill = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            aluop = v_op[i]; funct3 = v_f3[i]; funct7 = v_f7[i];
            @(posedge clk); #1;
            n_cmp++;
            if (alu_control_q !== v_exp[i] || illegal_q !== v_ill[i]) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b/%b want %b/%b",
                         i, alu_control_q, illegal_q, v_exp[i], v_ill[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b0; aluop = 3'b000; funct3 = 3'b000; funct7 = 7'b0;
        test_reset();
        test_r_type();
        test_i_type();
        test_add_classes();
        test_branch();
        test_jump();
        test_registered();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
